// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the main-memory arbiter.
//   - address / data widths of the word-addressed memory port
//   - requester indices (CPU, IOP)
//   - arbiter FSM state encodings
//   - mem_cmd_t: one buffered memory command (we / address / wdata)
// Bit numbering follows the rest of the machine: address bits [15:31],
// data bits [0:31], bit 0 / bit 15 being the most significant.
package mem_arbiter_pkg;

    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 32;

    localparam int PORT_CPU  = 0;
    localparam int PORT_IOP  = 1;
    localparam int NUM_PORTS = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef struct packed {
        logic        we;
        logic [15:31] address;
        logic [0:31]  wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_port_buffer.sv
// mem_port_buffer: per-requester front end of the memory arbiter.
// Captures a one-cycle command strobe into a pending buffer, reports busy,
// flags strobes that arrive while busy (sticky), and holds the last read
// data returned to this requester.
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   strobe, cmd_in   command strobe and the command sampled with it
//   take             arbiter has granted this buffer; clears pending
//   active           arbiter is performing this port's access
//   rd_load, rd_value load rdata with the memory read value
//   cmd              buffered command
//   pending, busy    command waiting / command waiting or in progress
//   error            sticky: strobe seen while busy
//   rdata            held read data
module mem_port_buffer
    import mem_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        strobe,
    input  mem_cmd_t    cmd_in,
    input  logic        take,
    input  logic        active,
    input  logic        rd_load,
    input  logic [0:31] rd_value,
    output mem_cmd_t    cmd,
    output logic        pending,
    output logic        busy,
    output logic        error,
    output logic [0:31] rdata
);

    // Not busy during the DONE cycle, so a strobe coinciding with ack is taken.
    assign busy = pending | active;

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd     <= '0;
            pending <= 1'b0;
            error   <= 1'b0;
            rdata   <= '0;
        end else begin
            // take only fires while pending (hence busy), so it never races
            // with an accepted strobe.
            if (strobe && !busy) begin
                cmd     <= cmd_in;
                pending <= 1'b1;
            end else if (take) begin
                pending <= 1'b0;
            end
            if (strobe && busy)
                error <= 1'b1;
            if (rd_load)
                rdata <= rd_value;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single word-addressed main-memory port between the
// CPU and the IOP. Each side strobes a command into its own buffer; the
// arbiter grants one buffer at a time, holds the memory access for
// WAIT_STATES+1 cycles, then pulses that side's ack for one cycle.
// Parameters:
//   WAIT_STATES   extra memory cycles per access (0..15)
//   IOP_PRIORITY  tie winner when both pending: 1 = IOP, 0 = CPU
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  ties go to the port not granted last (first tie
//                           goes to CPU); IOP_PRIORITY is then unused.
// Ports:
//   clock, reset                    clock, synchronous active-high reset
//   cpu_* / iop_*                   strobe, we, address, wdata in;
//                                   ack, rdata, busy out
//   mem_en, mem_we, mem_address,
//   mem_wdata, mem_rdata            memory port
//   protocol_error                  sticky: strobe while that port was busy
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_STATES  = 1,
    parameter bit IOP_PRIORITY = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_strobe,
    input  logic         cpu_we,
    input  logic [15:31] cpu_address,
    input  logic [0:31]  cpu_wdata,
    output logic         cpu_ack,
    output logic [0:31]  cpu_rdata,
    output logic         cpu_busy,
    input  logic         iop_strobe,
    input  logic         iop_we,
    input  logic [15:31] iop_address,
    input  logic [0:31]  iop_wdata,
    output logic         iop_ack,
    output logic [0:31]  iop_rdata,
    output logic         iop_busy,
    output logic         mem_en,
    output logic         mem_we,
    output logic [15:31] mem_address,
    output logic [0:31]  mem_wdata,
    input  logic [0:31]  mem_rdata,
    output logic         protocol_error
);

    logic [1:0]           state;
    logic [3:0]           count;
    logic                 grant;      // 0 = CPU, 1 = IOP
    logic                 next_grant;
    mem_cmd_t             mem_cmd_q;

    logic [NUM_PORTS-1:0] strobe_v, pend, busy_v, err, take, active, rd_load;
    mem_cmd_t             cmd_in  [NUM_PORTS];
    mem_cmd_t             cmd_buf [NUM_PORTS];
    logic [0:31]          rdata_v [NUM_PORTS];

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                 last_grant;
`endif

    assign strobe_v[PORT_CPU] = cpu_strobe;
    assign strobe_v[PORT_IOP] = iop_strobe;
    assign cmd_in[PORT_CPU]   = '{we: cpu_we, address: cpu_address, wdata: cpu_wdata};
    assign cmd_in[PORT_IOP]   = '{we: iop_we, address: iop_address, wdata: iop_wdata};

    // Winner among pending ports; only consulted in IDLE.
    always_comb begin
        next_grant = 1'b0;
        if (pend[PORT_CPU] && pend[PORT_IOP]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            next_grant = ~last_grant;
`else
            next_grant = IOP_PRIORITY;
`endif
        end else if (pend[PORT_IOP]) begin
            next_grant = 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign take[p]    = (state == ST_IDLE) && (|pend) && (next_grant == 1'(p));
        assign active[p]  = (state == ST_ACCESS) && (grant == 1'(p));
        // Capture on the final access cycle; writes leave rdata untouched.
        assign rd_load[p] = active[p] && (count == 4'd0) && !mem_cmd_q.we;

        mem_port_buffer u_buf (
            .clock    (clock),
            .reset    (reset),
            .strobe   (strobe_v[p]),
            .cmd_in   (cmd_in[p]),
            .take     (take[p]),
            .active   (active[p]),
            .rd_load  (rd_load[p]),
            .rd_value (mem_rdata),
            .cmd      (cmd_buf[p]),
            .pending  (pend[p]),
            .busy     (busy_v[p]),
            .error    (err[p]),
            .rdata    (rdata_v[p])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= 4'd0;
            grant     <= 1'b0;
            mem_cmd_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pend) begin
                        grant     <= next_grant;
                        mem_cmd_q <= cmd_buf[next_grant];
                        count     <= 4'(WAIT_STATES);
                        state     <= ST_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant <= next_grant;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (count == 4'd0)
                        state <= ST_DONE;
                    else
                        count <= count - 4'd1;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_en         = (state == ST_ACCESS);
    assign mem_we         = mem_en & mem_cmd_q.we;
    assign mem_address    = mem_cmd_q.address;
    assign mem_wdata      = mem_cmd_q.wdata;

    assign cpu_ack        = (state == ST_DONE) && (grant == 1'b0);
    assign iop_ack        = (state == ST_DONE) && (grant == 1'b1);
    assign cpu_busy       = busy_v[PORT_CPU];
    assign iop_busy       = busy_v[PORT_IOP];
    assign cpu_rdata      = rdata_v[PORT_CPU];
    assign iop_rdata      = rdata_v[PORT_IOP];
    assign protocol_error = |err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random transactions,
// all checked against a transaction-level model (reference memory, per-port
// expected rdata, expected ack latency from the cycle arithmetic).
module tb_mem_arbiter;

    localparam int WS  = 1;
    localparam int LAT = WS + 3;          // strobe-to-ack, idle arbiter
    localparam int WIN = 2 * LAT + 3;     // observation window per transaction

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic         cpu_strobe, cpu_we, cpu_ack, cpu_busy;
    logic [15:31] cpu_address;
    logic [0:31]  cpu_wdata, cpu_rdata;
    logic         iop_strobe, iop_we, iop_ack, iop_busy;
    logic [15:31] iop_address;
    logic [0:31]  iop_wdata, iop_rdata;
    logic         mem_en, mem_we, protocol_error;
    logic [15:31] mem_address;
    logic [0:31]  mem_wdata, mem_rdata;

    // second instance: zero wait states, CPU priority
    logic         z_cpu_strobe, z_cpu_ack, z_cpu_busy, z_iop_strobe, z_iop_ack, z_iop_busy;
    logic [15:31] z_cpu_address, z_iop_address, z_mem_address;
    logic [0:31]  z_cpu_rdata, z_iop_rdata, z_mem_wdata, z_mem_rdata;
    logic         z_mem_en, z_mem_we, z_perr;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] init_val(input int a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h0F0F1234);
    endfunction

    // memory device: untouched words read their initial pattern
    logic [0:31] dmem [0:131071];
    bit          dval [0:131071];
    always @(posedge clock)
        if (mem_en && mem_we) begin
            dmem[mem_address] <= mem_wdata;
            dval[mem_address] <= 1'b1;
        end
    assign mem_rdata   = dval[mem_address] ? dmem[mem_address] : init_val(int'(mem_address));
    assign z_mem_rdata = init_val(int'(z_mem_address));

    mem_arbiter #(.WAIT_STATES(WS), .IOP_PRIORITY(1'b1)) dut (
        .clock(clock), .reset(reset),
        .cpu_strobe(cpu_strobe), .cpu_we(cpu_we), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
        .iop_strobe(iop_strobe), .iop_we(iop_we), .iop_address(iop_address),
        .iop_wdata(iop_wdata), .iop_ack(iop_ack), .iop_rdata(iop_rdata), .iop_busy(iop_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .protocol_error(protocol_error)
    );

    mem_arbiter #(.WAIT_STATES(0), .IOP_PRIORITY(1'b0)) dut0 (
        .clock(clock), .reset(reset),
        .cpu_strobe(z_cpu_strobe), .cpu_we(1'b0), .cpu_address(z_cpu_address),
        .cpu_wdata(32'h0), .cpu_ack(z_cpu_ack), .cpu_rdata(z_cpu_rdata), .cpu_busy(z_cpu_busy),
        .iop_strobe(z_iop_strobe), .iop_we(1'b0), .iop_address(z_iop_address),
        .iop_wdata(32'h0), .iop_ack(z_iop_ack), .iop_rdata(z_iop_rdata), .iop_busy(z_iop_busy),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_address(z_mem_address),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata), .protocol_error(z_perr)
    );

    // ---------------- model state ----------------
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd [2];
    int          m_last = 1;              // last granted port (round-robin build)

    function automatic logic [31:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- observation of one transaction ----------------
    int          lat_c, lat_i, n_ack_c, n_ack_i, en_first, n_en, n_we;
    logic [31:0] last_a, last_d;

    task automatic run_pair(input bit do_c, input bit do_i, input bit dup_c,
                            input bit c_we, input int c_a, input logic [31:0] c_d,
                            input bit i_we, input int i_a, input logic [31:0] i_d);
        @(negedge clock);
        cpu_strobe = do_c; cpu_we = c_we; cpu_address = 17'(c_a); cpu_wdata = c_d;
        iop_strobe = do_i; iop_we = i_we; iop_address = 17'(i_a); iop_wdata = i_d;
        lat_c = -1; lat_i = -1; n_ack_c = 0; n_ack_i = 0; en_first = -1; n_en = 0; n_we = 0;
        for (int t = 1; t <= WIN; t++) begin
            @(negedge clock);
            if (cpu_ack) begin n_ack_c++; if (lat_c < 0) lat_c = t; end
            if (iop_ack) begin n_ack_i++; if (lat_i < 0) lat_i = t; end
            if (mem_en) begin
                n_en++;
                if (en_first < 0) en_first = t;
                last_a = 32'(mem_address); last_d = mem_wdata;
                if (mem_we) n_we++;
            end
            if (t == 1) begin iop_strobe = 1'b0; if (!dup_c) cpu_strobe = 1'b0; end
            if (t == 2) cpu_strobe = 1'b0;
        end
    endtask

    // run + model + compare
    task automatic do_txn(input string tag, input bit do_c, input bit do_i, input bit dup_c,
                          input bit c_we, input int c_a, input logic [31:0] c_d,
                          input bit i_we, input int i_a, input logic [31:0] i_d);
        int w, nw;
        int ord [$];
        run_pair(do_c, do_i, dup_c, c_we, c_a, c_d, i_we, i_a, i_d);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w = 1 - m_last;
`else
        w = 1;
`endif
        if (do_c && do_i) ord = '{w, 1 - w};
        else if (do_c)    ord = '{0};
        else if (do_i)    ord = '{1};
        nw = 0;
        foreach (ord[k]) begin
            if (ord[k] == 0) begin
                if (c_we) begin ref_mem[c_a] = c_d; nw++; end else exp_rd[0] = ref_read(c_a);
            end else begin
                if (i_we) begin ref_mem[i_a] = i_d; nw++; end else exp_rd[1] = ref_read(i_a);
            end
            m_last = ord[k];
        end
        if (do_c) chk({tag, ".cpu_lat"}, lat_c, (ord[0] == 0) ? LAT : 2 * LAT);
        if (do_i) chk({tag, ".iop_lat"}, lat_i, (ord[0] == 1) ? LAT : 2 * LAT);
        chk({tag, ".cpu_acks"}, n_ack_c, 32'(do_c));
        chk({tag, ".iop_acks"}, n_ack_i, 32'(do_i));
        chk({tag, ".en_cycles"}, n_en, (int'(do_c) + int'(do_i)) * (WS + 1));
        chk({tag, ".we_cycles"}, n_we, nw * (WS + 1));
        chk({tag, ".cpu_rdata"}, cpu_rdata, exp_rd[0]);
        chk({tag, ".iop_rdata"}, iop_rdata, exp_rd[1]);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_last = 1; exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    initial begin
        int l1, l2, ca, ia;
        reset = 1'b1;
        cpu_strobe = 0; cpu_we = 0; cpu_address = '0; cpu_wdata = '0;
        iop_strobe = 0; iop_we = 0; iop_address = '0; iop_wdata = '0;
        z_cpu_strobe = 0; z_iop_strobe = 0; z_cpu_address = '0; z_iop_address = '0;
        do_reset();

        // reset state
        @(negedge clock);
        chk("rst.acks",  {cpu_ack, iop_ack, cpu_busy, iop_busy}, 0);
        chk("rst.mem",   {mem_en, mem_we, protocol_error}, 0);
        chk("rst.maddr", mem_address, 0);
        chk("rst.mwdat", mem_wdata, 0);
        chk("rst.crd",   cpu_rdata, 0);
        chk("rst.ird",   iop_rdata, 0);

        // CPU read of preloaded word
        do_txn("cpu_rd", 1, 0, 0, 0, 32'h100, 0, 0, 0, 0);
        chk("cpu_rd.en_first", en_first, 2);
        chk("cpu_rd.value", cpu_rdata, 32'hDEADBEEF);

        // IOP write at top address, then CPU reads it back
        do_txn("iop_wr", 0, 1, 0, 0, 0, 0, 1, 32'h1FFFF, 32'h12345678);
        chk("iop_wr.addr", last_a, 32'h1FFFF);
        chk("iop_wr.data", last_d, 32'h12345678);
        do_txn("rd_back", 1, 0, 0, 0, 32'h1FFFF, 0, 0, 0, 0);
        chk("rd_back.value", cpu_rdata, 32'h12345678);

        // contention: two simultaneous pairs
        do_txn("tie1", 1, 1, 0, 0, 32'h40, 0, 0, 32'h41, 0);
        chk("tie1.spacing", lat_c - lat_i, LAT);
        do_txn("tie2", 1, 1, 0, 1, 32'h42, 32'hCAFE0001, 0, 32'h42, 0);

        // strobe while busy
        do_txn("dup", 1, 0, 1, 0, 32'h55, 0, 0, 0, 0);
        chk("dup.perr", protocol_error, 1);
        do_txn("after_dup", 0, 1, 0, 0, 0, 0, 0, 32'h56, 0);
        chk("after_dup.perr", protocol_error, 1);

        // back-to-back: new CPU strobe in the ack cycle
        @(negedge clock);
        cpu_strobe = 1; cpu_we = 0; cpu_address = 17'h200;
        @(negedge clock);
        cpu_strobe = 0;
        l1 = 1;
        while (!cpu_ack && l1 < 20) begin @(negedge clock); l1++; end
        chk("b2b.lat1", l1, LAT);
        cpu_strobe = 1; cpu_address = 17'h201;
        l2 = 0;
        do begin
            @(negedge clock); l2++;
            cpu_strobe = 0;
        end while (!cpu_ack && l2 < 20);
        chk("b2b.lat2", l2, LAT);
        exp_rd[0] = ref_read(32'h201); m_last = 0;
        chk("b2b.rdata", cpu_rdata, exp_rd[0]);

        // zero wait states, CPU priority instance
        @(negedge clock);
        z_cpu_strobe = 1; z_cpu_address = 17'h777;
        l1 = 0;
        do begin @(negedge clock); l1++; z_cpu_strobe = 0; end while (!z_cpu_ack && l1 < 20);
        chk("ws0.lat", l1, 3);
        chk("ws0.rdata", z_cpu_rdata, init_val(32'h777));
        @(negedge clock);
        z_cpu_strobe = 1; z_iop_strobe = 1; z_cpu_address = 17'h10; z_iop_address = 17'h11;
        l1 = -1; l2 = -1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clock);
            z_cpu_strobe = 0; z_iop_strobe = 0;
            if (z_cpu_ack && l1 < 0) l1 = t;
            if (z_iop_ack && l2 < 0) l2 = t;
        end
        chk("ws0.tie_cpu", l1, 3);
        chk("ws0.tie_iop", l2, 6);
        chk("ws0.iop_rdata", z_iop_rdata, init_val(32'h11));

        // reset in the middle of an access
        @(negedge clock);
        cpu_strobe = 1; cpu_we = 0; cpu_address = 17'h300;
        @(negedge clock); cpu_strobe = 0;
        @(negedge clock);
        chk("rmid.in_access", mem_en, 1);
        reset = 1;
        @(negedge clock);
        reset = 0;
        m_last = 1; exp_rd[0] = '0; exp_rd[1] = '0;
        chk("rmid.mem_en", mem_en, 0);
        chk("rmid.busy", cpu_busy, 0);
        chk("rmid.perr", protocol_error, 0);
        l1 = 0;
        for (int t = 0; t < 10; t++) begin @(negedge clock); if (cpu_ack) l1++; end
        chk("rmid.no_ack", l1, 0);
        chk("rmid.rdata", cpu_rdata, 0);
        do_txn("rmid.after", 1, 0, 0, 0, 32'h300, 0, 0, 0, 0);

        // random traffic over a small address pool to force collisions
        for (int n = 0; n < 30; n++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            ca = 32'h1000 + int'($urandom_range(0, 5));
            ia = 32'h1000 + int'($urandom_range(0, 5));
            do_txn($sformatf("rnd%0d", n), mode != 1, mode != 0, 0,
                   1'($urandom), ca, $urandom, 1'($urandom), ia, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
